// File: rtl/crypto_wallet_led_ctrl.sv
// rtl/crypto_wallet_led_ctrl.sv - LED/GPIO output controller with atomic set/clear and blink timebase
//
// Purpose:
//   Zero-wait-state register slave driving board LEDs. Provides a DATA register,
//   atomic OUTSET/OUTCLEAR strobes, a per-bit blink enable mask and a shared
//   programmable blink timebase. The output port is registered.
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      active-low reset; asserts asynchronously, releases synchronously
//   address     in   3      register word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data (bits above register width ignored)
//   readdata    out  32     combinational read data, zero-extended
//   out_port    out  WIDTH  registered LED/GPIO outputs
//
// Register map:
//   0 DATA rw, 1 BLINK rw, 2 PRESCALE rw, 3 OUTSET wo, 4 OUTCLEAR wo,
//   5 STATUS ro (bit0 = blink phase), 6 PORT ro, 7 reserved

module crypto_wallet_led_ctrl #(
  parameter int                WIDTH          = 8,
  parameter int                CNT_W          = 24,
  parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
  parameter logic [31:0]       PRESCALE_RESET = 32'd12_499_999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK    = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_PORT     = 3'd6;

  // Reset synchroniser: assertion propagates immediately, release is
  // aligned to clk after two stages so no flop sees a release near an edge.
  logic [1:0]        r_rst_sync;
  logic              w_rst_n;

  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  r_blink;
  logic [CNT_W-1:0]  r_prescale;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_phase;
  logic [WIDTH-1:0]  r_out;

  logic              w_wr;
  logic [WIDTH-1:0]  w_wdata;
  logic [CNT_W-1:0]  w_wdata_pre;
  logic              w_cnt_wrap;
  logic [31:0]       w_rdata;
  logic              w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_wr        = chipselect & ~write_n;
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_wdata_pre = writedata[CNT_W-1:0];
  assign w_cnt_wrap  = (r_cnt == r_prescale);

  // Upper writedata bits are deliberately ignored.
  assign w_unused = ^writedata;

  // DATA: direct write plus atomic read-modify-write strobes.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data <= w_wdata;
        ADDR_OUTSET:   r_data <= r_data | w_wdata;
        ADDR_OUTCLEAR: r_data <= r_data & ~w_wdata;
        default:       r_data <= r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_blink <= '0;
    end else if (w_wr && (address == ADDR_BLINK)) begin
      r_blink <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prescale <= PRESCALE_RESET[CNT_W-1:0];
    end else if (w_wr && (address == ADDR_PRESCALE)) begin
      r_prescale <= w_wdata_pre;
    end
  end

  // Blink timebase. A PRESCALE write restarts the on-phase so a new rate
  // takes effect cleanly and the counter can never exceed PRESCALE.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_wr && (address == ADDR_PRESCALE)) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_cnt_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Registered output keeps the LED pins glitch-free; blinking bits are
  // gated by the phase, non-blinking bits follow DATA.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= r_data & (~r_blink | {WIDTH{r_phase}});
    end
  end

  assign out_port = r_out;

  // Combinational read mux; reflects pre-write values during a write cycle.
  always_comb begin
    w_rdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:     w_rdata[WIDTH-1:0] = r_data;
        ADDR_BLINK:    w_rdata[WIDTH-1:0] = r_blink;
        ADDR_PRESCALE: w_rdata[CNT_W-1:0] = r_prescale;
        ADDR_STATUS:   w_rdata[0]         = r_phase;
        ADDR_PORT:     w_rdata[WIDTH-1:0] = r_out;
        default:       w_rdata            = '0;
      endcase
    end
  end

  assign readdata = w_rdata;

endmodule
